jt6821_pia: RTL and testbench

Host-side peripheral interface adapter that is the other end of the MCU's port A/B handshake. It implements the MC6821 PIA register model. The 8-bit host bus reads and writes two port sides, A and B. Each side has a data-direction register, a control register and CA1/CA2 (CB1/CB2) handshake lines, and drives the two interrupt outputs. On the mouse card it sits between the Apple II slot bus and the 6805 ports: PA/PB go to the MCU's `pa`/`pb` pins, and CA1/CB1 come from MCU strobes.

---
 rtl/jt6821_pkg.sv | 31 +++
 rtl/jt6821_side.sv | 90 +++++++++
 rtl/jt6821_pia.sv | 119 +++++++++++
 tb/tb_jt6821_pia.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt6821_pkg.sv
// Shared definitions for the jt6821 PIA: register-select codes, control
// register bit positions, C2 output modes and the C2 state encoding.
package jt6821_pkg;

  typedef enum logic [1:0] {
    RS_PA  = 2'd0,
    RS_CRA = 2'd1,
    RS_PB  = 2'd2,
    RS_CRB = 2'd3
  } rs_e;

  localparam int CR_C1EN   = 0;
  localparam int CR_C1EDGE = 1;
  localparam int CR_DDRSEL = 2;
  localparam int CR_C2EN   = 3;
  localparam int CR_C2EDGE = 4;
  localparam int CR_C2OUT  = 5;
  localparam int CR_F2     = 6;
  localparam int CR_F1     = 7;

  // CR[5:3] values for the two strobe-driven C2 output modes
  localparam logic [2:0] C2M_HANDSHAKE = 3'b100;
  localparam logic [2:0] C2M_PULSE     = 3'b101;

  typedef enum logic [1:0] {
    C2_IDLE      = 2'd0,
    C2_HS_LOW    = 2'd1,
    C2_PULSE_LOW = 2'd2
  } c2_state_e;

endpackage

// File: rtl/jt6821_side.sv
// One PIA side: control register, IRQ flags, C1/C2 synchronisers and the
// C2 output state machine. Side A triggers C2 on OR reads, side B on writes.
module jt6821_side
  import jt6821_pkg::*;
#(
  parameter bit TRIG_ON_WRITE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cr_we,
  input  logic [5:0] cr_wdata,
  input  logic       or_rd,
  input  logic       or_wr,
  input  logic       c1,
  input  logic       c2_in,
  output logic [7:0] cr,
  output logic       irq,
  output logic       c2_out
);

  logic [5:0] ctl_q, ctl_d;
  logic       f1_q, f1_d, f2_q, f2_d;
  logic [2:0] c1_sh_q, c1_sh_d, c2_sh_q, c2_sh_d;
  c2_state_e  state_q, state_d;
  logic       c1_edge, c2_edge, trig;

  // NOTE: every combinational output gets a default at the top of the block,
  // so no path can leave a value unassigned and infer a latch.
  always_comb begin
    c1_sh_d = {c1_sh_q[1:0], c1};
    c2_sh_d = {c2_sh_q[1:0], c2_in};
    // bit 1 is the synchronised level, bit 2 its previous value
    c1_edge = ctl_q[CR_C1EDGE] ? (c1_sh_q[1] & ~c1_sh_q[2])
                               : (~c1_sh_q[1] & c1_sh_q[2]);
    c2_edge = ~ctl_q[CR_C2OUT] &
              (ctl_q[CR_C2EDGE] ? (c2_sh_q[1] & ~c2_sh_q[2])
                                : (~c2_sh_q[1] & c2_sh_q[2]));
    trig    = TRIG_ON_WRITE ? or_wr : or_rd;

    ctl_d = cr_we ? cr_wdata : ctl_q;
    // a set on the same edge as a clearing read wins
    f1_d  = c1_edge | (f1_q & ~or_rd);
    f2_d  = c2_edge | (f2_q & ~or_rd);

    state_d = state_q;
    if (cr_we) begin
      state_d = C2_IDLE;
    end else begin
      unique case (state_q)
        C2_IDLE: begin
          if (trig && ctl_q[CR_C2OUT:CR_C2EN] == C2M_HANDSHAKE) state_d = C2_HS_LOW;
          if (trig && ctl_q[CR_C2OUT:CR_C2EN] == C2M_PULSE)     state_d = C2_PULSE_LOW;
        end
        C2_HS_LOW:    if (c1_edge) state_d = C2_IDLE;
        C2_PULSE_LOW: if (cen)     state_d = C2_IDLE;
        default:      state_d = C2_IDLE;
      endcase
    end

    c2_out = 1'b1;
    if (ctl_q[CR_C2OUT]) begin
      c2_out = ctl_q[CR_C2EDGE] ? ctl_q[CR_C2EN] : (state_q == C2_IDLE);
    end

    cr  = {f1_q, f2_q, ctl_q};
    irq = (f1_q & ctl_q[CR_C1EN]) | (f2_q & ctl_q[CR_C2EN] & ~ctl_q[CR_C2OUT]);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q   <= '0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      c1_sh_q <= '0;
      c2_sh_q <= '0;
      state_q <= C2_IDLE;
    end else begin
      ctl_q   <= ctl_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      c1_sh_q <= c1_sh_d;
      c2_sh_q <= c2_sh_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/jt6821_pia.sv
// MC6821-style PIA: port output/direction registers, host read mux and two
// handshake sides.
module jt6821_pia
  import jt6821_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs,
  input  logic [1:0] rs,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irqa,
  output logic       irqb,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pa_oe,
  output logic [7:0] pb_oe,
  input  logic       ca1,
  input  logic       cb1,
  input  logic       ca2_in,
  input  logic       cb2_in,
  output logic       ca2_out,
  output logic       cb2_out
);

  logic [7:0] ora_q, ora_d, ddra_q, ddra_d, orb_q, orb_d, ddrb_q, ddrb_d;
  logic [7:0] cra, crb;
  logic       acc_wr, acc_rd;
  logic       or_sel_a, ddr_sel_a, or_sel_b, ddr_sel_b;
  logic       cra_we, crb_we, ora_rd, ora_wr, orb_rd, orb_wr;
  rs_e        rs_sel;

  always_comb begin
    rs_sel = rs_e'(rs);
    acc_wr = cs & cen & wr;
    acc_rd = cs & cen & ~wr;

    or_sel_a  = (rs_sel == RS_PA) &  cra[CR_DDRSEL];
    ddr_sel_a = (rs_sel == RS_PA) & ~cra[CR_DDRSEL];
    or_sel_b  = (rs_sel == RS_PB) &  crb[CR_DDRSEL];
    ddr_sel_b = (rs_sel == RS_PB) & ~crb[CR_DDRSEL];

    cra_we = acc_wr & (rs_sel == RS_CRA);
    crb_we = acc_wr & (rs_sel == RS_CRB);
    ora_rd = acc_rd & or_sel_a;
    ora_wr = acc_wr & or_sel_a;
    orb_rd = acc_rd & or_sel_b;
    orb_wr = acc_wr & or_sel_b;

    ora_d  = ora_wr                ? din : ora_q;
    ddra_d = (acc_wr & ddr_sel_a)  ? din : ddra_q;
    orb_d  = orb_wr                ? din : orb_q;
    ddrb_d = (acc_wr & ddr_sel_b)  ? din : ddrb_q;

    dout = 8'h00;
    unique case (rs_sel)
      RS_PA:  dout = cra[CR_DDRSEL] ? pa_in : ddra_q;
      RS_CRA: dout = cra;
      // port B reads back its own drivers on output bits
      RS_PB:  dout = crb[CR_DDRSEL] ? ((orb_q & ddrb_q) | (pb_in & ~ddrb_q)) : ddrb_q;
      RS_CRB: dout = crb;
      default: dout = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ora_q  <= '0;
      ddra_q <= '0;
      orb_q  <= '0;
      ddrb_q <= '0;
    end else begin
      ora_q  <= ora_d;
      ddra_q <= ddra_d;
      orb_q  <= orb_d;
      ddrb_q <= ddrb_d;
    end
  end

  assign pa_out = ora_q;
  assign pa_oe  = ddra_q;
  assign pb_out = orb_q;
  assign pb_oe  = ddrb_q;

  jt6821_side #(.TRIG_ON_WRITE(1'b0)) u_side_a (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .cr_we    (cra_we),
    .cr_wdata (din[5:0]),
    .or_rd    (ora_rd),
    .or_wr    (ora_wr),
    .c1       (ca1),
    .c2_in    (ca2_in),
    .cr       (cra),
    .irq      (irqa),
    .c2_out   (ca2_out)
  );

  jt6821_side #(.TRIG_ON_WRITE(1'b1)) u_side_b (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .cr_we    (crb_we),
    .cr_wdata (din[5:0]),
    .or_rd    (orb_rd),
    .or_wr    (orb_wr),
    .c1       (cb1),
    .c2_in    (cb2_in),
    .cr       (crb),
    .irq      (irqb),
    .c2_out   (cb2_out)
  );

endmodule

// File: tb/tb_jt6821_pia.sv
// Directed bench for jt6821_pia: a register-map vector table followed by
// hand-written interrupt, handshake, pulse, collision and reset sequences.
module tb_jt6821_pia;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       cs = 1'b0;
  logic [1:0] rs = 2'd0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irqa, irqb;
  logic [7:0] pa_in = 8'h00, pb_in = 8'h00;
  logic [7:0] pa_out, pb_out, pa_oe, pb_oe;
  logic       ca1 = 1'b0, cb1 = 1'b0, ca2_in = 1'b0, cb2_in = 1'b0;
  logic       ca2_out, cb2_out;

  int n_tests = 0;
  int n_fail  = 0;

  jt6821_pia dut (
    .clk(clk), .rst(rst), .cen(cen), .cs(cs), .rs(rs), .wr(wr), .din(din),
    .dout(dout), .irqa(irqa), .irqb(irqb), .pa_in(pa_in), .pb_in(pb_in),
    .pa_out(pa_out), .pb_out(pb_out), .pa_oe(pa_oe), .pb_oe(pb_oe),
    .ca1(ca1), .cb1(cb1), .ca2_in(ca2_in), .cb2_in(cb2_in),
    .ca2_out(ca2_out), .cb2_out(cb2_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       wr;
    bit [1:0] rs;
    bit [7:0] data;       // write data, or expected read data
    bit [7:0] pa_pin;
    bit [7:0] pb_pin;
    bit [7:0] exp_pa_out;
    bit [7:0] exp_pa_oe;
    bit [7:0] exp_pb_out;
    bit [7:0] exp_pb_oe;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; rs = a; din = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b0; rs = a;
    #1;
    d = dout;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  logic [7:0] rd;

  initial begin
    vecs[0]  = '{1'b1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 2'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 2'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 2'd1, 8'h04, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 2'd0, 8'h5A, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 2'd1, 8'h04, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 2'd0, 8'hC3, 8'hC3, 8'h00, 8'h5A, 8'hFF, 8'h00, 8'h00};
    vecs[7]  = '{1'b1, 2'd2, 8'h0F, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'h00, 8'h0F};
    vecs[8]  = '{1'b1, 2'd3, 8'h04, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'h00, 8'h0F};
    vecs[9]  = '{1'b1, 2'd2, 8'hA5, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'hA5, 8'h0F};
    vecs[10] = '{1'b0, 2'd2, 8'h35, 8'h00, 8'h3C, 8'h5A, 8'hFF, 8'hA5, 8'h0F};
    vecs[11] = '{1'b0, 2'd3, 8'h04, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'hA5, 8'h0F};
    vecs[12] = '{1'b1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'hA5, 8'h0F};
    vecs[13] = '{1'b0, 2'd0, 8'hFF, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'hA5, 8'h0F};

    // reset state
    wait_clk(3);
    check("rst ca2_out", {7'd0, ca2_out}, 8'h01);
    check("rst cb2_out", {7'd0, cb2_out}, 8'h01);
    check("rst irqa", {7'd0, irqa}, 8'h00);
    check("rst irqb", {7'd0, irqb}, 8'h00);
    check("rst pa_out", pa_out, 8'h00);
    check("rst pb_oe", pb_oe, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(2);

    // register map
    for (int i = 0; i < 14; i++) begin
      pa_in = vecs[i].pa_pin;
      pb_in = vecs[i].pb_pin;
      if (vecs[i].wr) begin
        bus_write(vecs[i].rs, vecs[i].data);
      end else begin
        bus_read(vecs[i].rs, rd);
        check($sformatf("vec%0d dout", i), rd, vecs[i].data);
      end
      check($sformatf("vec%0d pa_out", i), pa_out, vecs[i].exp_pa_out);
      check($sformatf("vec%0d pa_oe", i), pa_oe, vecs[i].exp_pa_oe);
      check($sformatf("vec%0d pb_out", i), pb_out, vecs[i].exp_pb_out);
      check($sformatf("vec%0d pb_oe", i), pb_oe, vecs[i].exp_pb_oe);
    end
    pa_in = 8'h00;
    pb_in = 8'h00;

    // CA1 rising-edge interrupt, 3 clk latency, cleared by ORA read
    bus_write(2'd1, 8'h07);
    @(negedge clk);
    ca1 = 1'b1;
    wait_clk(2);
    check("ca1 irqa at 2clk", {7'd0, irqa}, 8'h00);
    wait_clk(1);
    check("ca1 irqa at 3clk", {7'd0, irqa}, 8'h01);
    bus_read(2'd1, rd);
    check("ca1 cra flagged", rd, 8'h87);
    bus_read(2'd0, rd);
    check("ca1 irqa cleared", {7'd0, irqa}, 8'h00);
    bus_read(2'd1, rd);
    check("ca1 cra cleared", rd, 8'h07);

    // falling-edge select with enable off
    @(negedge clk);
    ca1 = 1'b0;
    wait_clk(4);
    bus_write(2'd1, 8'h04);
    @(negedge clk);
    ca1 = 1'b1;
    wait_clk(4);
    bus_read(2'd1, rd);
    check("fall rise ignored", rd, 8'h04);
    @(negedge clk);
    ca1 = 1'b0;
    wait_clk(4);
    bus_read(2'd1, rd);
    check("fall flag set", rd, 8'h84);
    check("fall irqa masked", {7'd0, irqa}, 8'h00);
    bus_read(2'd0, rd);
    bus_read(2'd1, rd);
    check("fall flag cleared", rd, 8'h04);

    // CA2 handshake: low on ORA read, high on next CA1 active edge
    bus_write(2'd1, 8'h26);
    check("hs ca2 idle", {7'd0, ca2_out}, 8'h01);
    bus_read(2'd0, rd);
    check("hs ca2 low", {7'd0, ca2_out}, 8'h00);
    wait_clk(10);
    check("hs ca2 held", {7'd0, ca2_out}, 8'h00);
    @(negedge clk);
    ca1 = 1'b1;
    wait_clk(2);
    check("hs ca2 before edge", {7'd0, ca2_out}, 8'h00);
    wait_clk(1);
    check("hs ca2 released", {7'd0, ca2_out}, 8'h01);
    bus_read(2'd1, rd);
    check("hs cra", rd, 8'hA6);
    // mode change mid-handshake reloads C2
    bus_read(2'd0, rd);
    check("hs retrigger", {7'd0, ca2_out}, 8'h00);
    bus_write(2'd1, 8'h04);
    check("hs mode change", {7'd0, ca2_out}, 8'h01);

    // CB2 pulse on ORB write, released at the next cen cycle
    bus_write(2'd3, 8'h2C);
    bus_write(2'd2, 8'h33);
    cen = 1'b0;
    check("pulse pb_out", pb_out, 8'h33);
    check("pulse cb2 low", {7'd0, cb2_out}, 8'h00);
    wait_clk(3);
    check("pulse cb2 no cen", {7'd0, cb2_out}, 8'h00);
    cen = 1'b1;
    wait_clk(1);
    check("pulse cb2 released", {7'd0, cb2_out}, 8'h01);
    bus_write(2'd3, 8'h38);
    check("manual cb2 high", {7'd0, cb2_out}, 8'h01);
    bus_write(2'd3, 8'h30);
    check("manual cb2 low", {7'd0, cb2_out}, 8'h00);

    // flag set and clearing read on the same edge: set wins
    @(negedge clk);
    ca1 = 1'b0;
    wait_clk(4);
    bus_read(2'd0, rd);
    bus_write(2'd1, 8'h07);
    @(negedge clk);
    ca1 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("coll irqa before", {7'd0, irqa}, 8'h00);
    bus_read(2'd0, rd);
    check("coll irqa kept", {7'd0, irqa}, 8'h01);
    bus_read(2'd1, rd);
    check("coll cra kept", rd, 8'h87);
    bus_read(2'd0, rd);
    bus_read(2'd1, rd);
    check("coll cra cleared", rd, 8'h07);

    // CB2 input rising edge with C2 interrupt enabled
    bus_write(2'd3, 8'h1C);
    check("cb2in cb2_out", {7'd0, cb2_out}, 8'h01);
    @(negedge clk);
    cb2_in = 1'b1;
    wait_clk(2);
    check("cb2in irqb 2clk", {7'd0, irqb}, 8'h00);
    wait_clk(1);
    check("cb2in irqb 3clk", {7'd0, irqb}, 8'h01);
    bus_read(2'd3, rd);
    check("cb2in crb", rd, 8'h5C);
    bus_read(2'd2, rd);
    check("cb2in irqb cleared", {7'd0, irqb}, 8'h00);
    @(negedge clk);
    cb2_in = 1'b0;
    wait_clk(4);
    check("cb2in fall ignored", {7'd0, irqb}, 8'h00);
    cb2_in = 1'b1;
    wait_clk(4);
    check("cb2in irqb again", {7'd0, irqb}, 8'h01);

    // asynchronous reset in the middle of a handshake
    bus_write(2'd1, 8'h26);
    bus_read(2'd0, rd);
    check("arst ca2 low", {7'd0, ca2_out}, 8'h00);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst ca2_out", {7'd0, ca2_out}, 8'h01);
    check("arst irqb", {7'd0, irqb}, 8'h00);
    check("arst pb_out", pb_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    bus_read(2'd3, rd);
    check("arst crb", rd, 8'h00);
    bus_read(2'd1, rd);
    check("arst cra", rd, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
